// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through L1 data cache NRU replacement engine.
package wt_cache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS = 64;

  // Reuse prediction meaning "this line will not be touched again after fill".
  localparam logic [1:0] NRU_PRED_DEAD = 2'b11;

  typedef enum logic {
    NRU_IDLE,
    NRU_FLUSH
  } nru_state_e;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
module lzc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     empty_o
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_o = '0;
    // Scanning from the top down lets the lowest set bit overwrite last.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = ($clog2(WIDTH))'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/wt_dcache_nru_victim.sv
// Combinational victim picker: first invalid way, else first NRU candidate, else way 0.
module wt_dcache_nru_victim #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] vld_ways,
  input  logic [NUM_WAYS-1:0] nru_bits,
  output logic [WAY_W-1:0]    way,
  output logic                found
);

  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] nru_way;
  logic             inv_empty;
  logic             nru_empty;

  lzc #(.WIDTH(NUM_WAYS)) u_inv_lzc (
    .in_i    (~vld_ways),
    .cnt_o   (inv_way),
    .empty_o (inv_empty)
  );

  lzc #(.WIDTH(NUM_WAYS)) u_nru_lzc (
    .in_i    (nru_bits),
    .cnt_o   (nru_way),
    .empty_o (nru_empty)
  );

  assign found = ~inv_empty | ~nru_empty;
  assign way   = !inv_empty ? inv_way :
                 !nru_empty ? nru_way : '0;

endmodule

// File: rtl/wt_dcache_nru_repl.sv
// NRU replacement engine for the write-through L1 dcache: flush walk, hit updates, registered victim handshake.
// Optional feature macro: WT_DCACHE_NRU_PRED_EN (dead-on-fill lines stay replacement candidates).
module wt_dcache_nru_repl
  import wt_cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = DCACHE_NUM_WORDS,
  parameter int unsigned WAY_W    = $clog2(NUM_WAYS),
  parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                hit_i,
  input  logic [IDX_W-1:0]    hit_idx_i,
  input  logic [WAY_W-1:0]    hit_way_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IDX_W-1:0]    req_idx_i,
  input  logic [NUM_WAYS-1:0] req_vld_ways_i,
  input  logic [1:0]          pred_result_i,
  output logic                rsp_valid_o,
  output logic [WAY_W-1:0]    rsp_way_o,
  output logic                busy_o,
  output logic                flush_done_o
);

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  nru_state_e          state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                flush_done;
  logic                rsp_valid_q;
  logic [WAY_W-1:0]    rsp_way_q;

  logic [NUM_WAYS-1:0] nru_q [NUM_SETS];

  logic                req_fire;
  logic                hit_en;
  logic                same_set;
  logic                pred_dead;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_found;
  logic [NUM_WAYS-1:0] hit_oh;
  logic [NUM_WAYS-1:0] vic_oh;
  logic [NUM_WAYS-1:0] hit_bits;
  logic [NUM_WAYS-1:0] alloc_base;
  logic [NUM_WAYS-1:0] alloc_touched;
  logic [NUM_WAYS-1:0] alloc_bits;

`ifdef WT_DCACHE_NRU_PRED_EN
  assign pred_dead = (pred_result_i == NRU_PRED_DEAD);
`else
  logic unused_pred;
  assign unused_pred = ^pred_result_i;
  assign pred_dead   = 1'b0;
`endif

  // A set must never end up with no candidate: refill it with every way not just used.
  function automatic logic [NUM_WAYS-1:0] saturate(input logic [NUM_WAYS-1:0] bits,
                                                    input logic [NUM_WAYS-1:0] touched,
                                                    input logic [NUM_WAYS-1:0] keep_clear);
    if (bits != '0)     return bits;
    if (touched != '1)  return ~touched;
    return ~keep_clear;
  endfunction

  assign req_ready_o  = (state_q == NRU_IDLE) & ~flush_i;
  assign busy_o       = (state_q == NRU_FLUSH);
  assign flush_done_o = flush_done;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_way_o    = rsp_way_q;

  assign req_fire = req_valid_i & req_ready_o;
  assign hit_en   = hit_i & (state_q == NRU_IDLE);
  assign same_set = hit_en & req_fire & (hit_idx_i == req_idx_i);

  wt_dcache_nru_victim #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim (
    .vld_ways (req_vld_ways_i),
    .nru_bits (nru_q[req_idx_i]),
    .way      (victim_way),
    .found    (victim_found)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_done = 1'b0;
    unique case (state_q)
      NRU_IDLE: begin
        if (flush_i) begin
          state_d = NRU_FLUSH;
          cnt_d   = '0;
        end
      end
      NRU_FLUSH: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_SET) begin
          state_d    = NRU_IDLE;
          flush_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Hit and allocation share one merged write when they target the same set.
  always_comb begin
    hit_oh        = NUM_WAYS'(1) << hit_way_i;
    vic_oh        = NUM_WAYS'(1) << victim_way;
    hit_bits      = saturate(nru_q[hit_idx_i] & ~hit_oh, hit_oh, hit_oh);
    alloc_base    = nru_q[req_idx_i];
    alloc_touched = vic_oh;
    if (same_set) begin
      alloc_base    = alloc_base & ~hit_oh;
      alloc_touched = alloc_touched | hit_oh;
    end
    alloc_base = pred_dead ? (alloc_base | vic_oh) : (alloc_base & ~vic_oh);
    alloc_bits = saturate(alloc_base, alloc_touched, vic_oh);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= NRU_FLUSH;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= req_fire;
      if (req_fire) rsp_way_q <= victim_way;
    end
  end

  // NOTE: the NRU array is not reset; the flush walk that reset starts initialises every set.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == NRU_FLUSH) begin
        nru_q[cnt_q] <= '1;
      end else begin
        if (hit_en && !same_set) nru_q[hit_idx_i] <= hit_bits;
        if (req_fire)            nru_q[req_idx_i] <= alloc_bits;
      end
    end
  end

  a_victim_found: assert property (@(posedge clk_i) disable iff (rst_i) req_fire |-> victim_found);

endmodule

// File: tb/tb_wt_dcache_nru_repl.sv
// Directed self-checking bench for wt_dcache_nru_repl (4 ways, 64 sets).
module tb_wt_dcache_nru_repl;
  import wt_cache_pkg::*;

  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned NUM_SETS = 64;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned IDX_W    = 6;

`ifdef WT_DCACHE_NRU_PRED_EN
  localparam int DEAD_SECOND = 0;
`else
  localparam int DEAD_SECOND = 1;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic                hit_i;
  logic [IDX_W-1:0]    hit_idx_i;
  logic [WAY_W-1:0]    hit_way_i;
  logic                req_valid_i;
  logic                req_ready_o;
  logic [IDX_W-1:0]    req_idx_i;
  logic [NUM_WAYS-1:0] req_vld_ways_i;
  logic [1:0]          pred_result_i;
  logic                rsp_valid_o;
  logic [WAY_W-1:0]    rsp_way_o;
  logic                busy_o;
  logic                flush_done_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, at, dn;

  always #5 clk_i = ~clk_i;

  wt_dcache_nru_repl #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS),
    .WAY_W    (WAY_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .hit_i          (hit_i),
    .hit_idx_i      (hit_idx_i),
    .hit_way_i      (hit_way_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_idx_i      (req_idx_i),
    .req_vld_ways_i (req_vld_ways_i),
    .pred_result_i  (pred_result_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_way_o      (rsp_way_o),
    .busy_o         (busy_o),
    .flush_done_o   (flush_done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All stimulus changes and all sampling happen 4 ns after a rising edge.
  task automatic step();
    @(posedge clk_i);
    #4;
  endtask

  task automatic wait_walk(output int cycles, output int done_at, output int dones);
    cycles  = 0;
    done_at = -1;
    dones   = 0;
    while (busy_o && cycles < 4 * NUM_SETS) begin
      if (flush_done_o) begin
        dones++;
        done_at = cycles;
      end
      cycles++;
      step();
    end
  endtask

  task automatic do_req(input string tag, input logic [IDX_W-1:0] idx,
                        input logic [NUM_WAYS-1:0] vld, input logic [1:0] pred, input int exp_way);
    req_valid_i    = 1'b1;
    req_idx_i      = idx;
    req_vld_ways_i = vld;
    pred_result_i  = pred;
    step();
    req_valid_i    = 1'b0;
    pred_result_i  = 2'b00;
    check({tag, "_vld"}, rsp_valid_o, 1);
    check(tag, rsp_way_o, exp_way);
  endtask

  task automatic do_hit(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way);
    hit_i     = 1'b1;
    hit_idx_i = idx;
    hit_way_i = way;
    step();
    hit_i     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; hit_i = 1'b0; hit_idx_i = '0; hit_way_i = '0;
    req_valid_i = 1'b0; req_idx_i = '0; req_vld_ways_i = '0; pred_result_i = 2'b00;
    repeat (3) step();

    check("rst_busy", busy_o, 1);
    check("rst_ready", req_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_way", rsp_way_o, 0);
    check("rst_flush_done", flush_done_o, 0);

    rst_i = 1'b0;
    wait_walk(cyc, at, dn);
    check("walk_cycles", cyc, NUM_SETS);
    check("walk_done_pulses", dn, 1);
    check("walk_done_at", at, NUM_SETS - 1);
    check("ready_after_walk", req_ready_o, 1);

    // Invalid way beats an NRU candidate at a lower index.
    do_req("set5_invalid", 6'd5, 4'b1011, 2'b00, 2);
    do_req("set5_nru", 6'd5, 4'b1111, 2'b00, 0);
    step();
    check("rsp_valid_drops", rsp_valid_o, 0);

    // Hits on ways 0..2, then allocation saturates the set.
    do_hit(6'd3, 2'd0);
    do_hit(6'd3, 2'd1);
    do_hit(6'd3, 2'd2);
    do_req("set3_first", 6'd3, 4'b1111, 2'b00, 3);
    do_req("set3_after_sat", 6'd3, 4'b1111, 2'b00, 0);
    do_req("set3_third", 6'd3, 4'b1111, 2'b00, 1);

    // Hit and request to the same set in one cycle: bits become 4'b1100.
    hit_i = 1'b1; hit_idx_i = 6'd7; hit_way_i = 2'd1;
    do_req("set7_same_cycle", 6'd7, 4'b1111, 2'b00, 0);
    hit_i = 1'b0;
    do_req("set7_next", 6'd7, 4'b1111, 2'b00, 2);
    do_req("set7_last", 6'd7, 4'b1111, 2'b00, 3);
    do_req("set7_wrap", 6'd7, 4'b1111, 2'b00, 0);

    // Hit and request to different sets update independently.
    hit_i = 1'b1; hit_idx_i = 6'd12; hit_way_i = 2'd0;
    do_req("set13_indep", 6'd13, 4'b1111, 2'b00, 0);
    hit_i = 1'b0;
    do_req("set12_after_hit", 6'd12, 4'b1111, 2'b00, 1);
    do_req("set13_after_req", 6'd13, 4'b1111, 2'b00, 1);

    // Back-to-back requests to set 9 with a dead-on-fill prediction.
    req_valid_i = 1'b1; req_idx_i = 6'd9; req_vld_ways_i = 4'b1111; pred_result_i = 2'b11;
    step();
    check("b2b_1_vld", rsp_valid_o, 1);
    check("b2b_1_way", rsp_way_o, 0);
    step();
    req_valid_i = 1'b0; pred_result_i = 2'b00;
    check("b2b_2_vld", rsp_valid_o, 1);
    check("b2b_2_way", rsp_way_o, DEAD_SECOND);

    // Response stays valid in the cycle flush_i is raised.
    do_req("set20_invalid_top", 6'd20, 4'b0111, 2'b00, 3);
    flush_i = 1'b1;
    #1;
    check("ready_low_on_flush", req_ready_o, 0);
    check("rsp_survives_flush", rsp_valid_o, 1);
    step();
    flush_i = 1'b0;
    check("busy_after_flush", busy_o, 1);

    // Hits during the walk are ignored; flush_i at cycle 10 restarts the walk.
    repeat (3) step();
    do_hit(6'd1, 2'd0);
    do_hit(6'd1, 2'd1);
    repeat (5) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_walk(cyc, at, dn);
    check("reflush_cycles", cyc, NUM_SETS);
    check("reflush_done_pulses", dn, 1);
    check("reflush_done_at", at, NUM_SETS - 1);
    do_req("set1_after_walk", 6'd1, 4'b1111, 2'b00, 0);
    do_req("set1_second", 6'd1, 4'b1111, 2'b00, 1);
    do_req("set3_after_walk", 6'd3, 4'b1111, 2'b00, 0);

    // Reset clears an in-flight response and restarts a walk in progress.
    req_valid_i = 1'b1; req_idx_i = 6'd0; req_vld_ways_i = 4'b1111; rst_i = 1'b1;
    step();
    rst_i = 1'b0; req_valid_i = 1'b0;
    check("rst_kills_rsp", rsp_valid_o, 0);
    check("rst_busy_again", busy_o, 1);
    repeat (10) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    wait_walk(cyc, at, dn);
    check("rst_midwalk_cycles", cyc, NUM_SETS);
    check("rst_midwalk_done_pulses", dn, 1);
    do_req("set7_after_reset", 6'd7, 4'b1111, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
